// File: rtl/idu_pipe_stage.sv
// idu_pipe_stage: pipelined RV32I/E decode stage with an integrated register file,
// per-register busy scoreboard (RAW/WAW stall), optional WB->read bypass and flush.
module idu_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wen,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  localparam logic [3:0] OP_LUI     = 4'd0;
  localparam logic [3:0] OP_AUIPC   = 4'd1;
  localparam logic [3:0] OP_JAL     = 4'd2;
  localparam logic [3:0] OP_JALR    = 4'd3;
  localparam logic [3:0] OP_BRANCH  = 4'd4;
  localparam logic [3:0] OP_LOAD    = 4'd5;
  localparam logic [3:0] OP_STORE   = 4'd6;
  localparam logic [3:0] OP_OPIMM   = 4'd7;
  localparam logic [3:0] OP_OP      = 4'd8;
  localparam logic [3:0] OP_EBREAK  = 4'd9;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  // Register fields wider than the file only matter for the reduced (RV32E) file.
  localparam bit         SMALL_RF = (NREG < 32);
  localparam logic [5:0] NREG_W   = 6'(NREG);

  // Decode results
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_field, rs2_field, rd_field;
  logic [AW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [3:0]      dec_op;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic            rs1_used, rs2_used, writes_rd, dec_rd_wen;

  // Hazard / handshake
  logic [NREG-1:0] busy_eff;
  logic            hazard, accept, issue;
  logic [XLEN-1:0] rs1_rd_data, rs2_rd_data;

  // State
  logic [XLEN-1:0] reg_q [NREG];
  logic [XLEN-1:0] reg_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [3:0]      out_op_q, out_op_d;
  logic [2:0]      out_funct3_q, out_funct3_d;
  logic            out_funct7b5_q, out_funct7b5_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [AW-1:0]   out_rd_q, out_rd_d;
  logic            out_rd_wen_q, out_rd_wen_d;

  assign opcode    = in_inst[6:0];
  assign funct3    = in_inst[14:12];
  assign funct7    = in_inst[31:25];
  assign rs1_field = in_inst[19:15];
  assign rs2_field = in_inst[24:20];
  assign rd_field  = in_inst[11:7];
  assign rs1_idx   = rs1_field[AW-1:0];
  assign rs2_idx   = rs2_field[AW-1:0];
  assign rd_idx    = rd_field[AW-1:0];

  // Classify the instruction, build its 32-bit immediate and operand usage.
  always_comb begin
    dec_op    = OP_ILLEGAL;
    imm32     = 32'd0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      7'b0110111: begin
        dec_op = OP_LUI; imm32 = {in_inst[31:12], 12'd0}; writes_rd = 1'b1;
      end
      7'b0010111: begin
        dec_op = OP_AUIPC; imm32 = {in_inst[31:12], 12'd0}; writes_rd = 1'b1;
      end
      7'b1101111: begin
        dec_op = OP_JAL; writes_rd = 1'b1;
        imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: if (funct3 == 3'b000) begin
        dec_op = OP_JALR; rs1_used = 1'b1; writes_rd = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) begin
        dec_op = OP_BRANCH; rs1_used = 1'b1; rs2_used = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
        dec_op = OP_LOAD; rs1_used = 1'b1; writes_rd = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
        dec_op = OP_STORE; rs1_used = 1'b1; rs2_used = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b0010011: begin
        dec_op = OP_OPIMM; rs1_used = 1'b1; writes_rd = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0110011: if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
        dec_op = OP_OP; rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
      end
      7'b1110011: if (in_inst == 32'h0010_0073) begin
        dec_op = OP_EBREAK;
      end
      default: ;
    endcase
    // A register field outside the reduced file turns the whole thing into a trap.
    if (SMALL_RF && ((rs1_used  && ({1'b0, rs1_field} >= NREG_W)) ||
                     (rs2_used  && ({1'b0, rs2_field} >= NREG_W)) ||
                     (writes_rd && ({1'b0, rd_field}  >= NREG_W)))) begin
      dec_op    = OP_ILLEGAL;
      imm32     = 32'd0;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      writes_rd = 1'b0;
    end
  end

  assign dec_imm    = XLEN'($signed(imm32));
  assign dec_rd_wen = writes_rd & (rd_idx != '0);

  // A busy bit being cleared by this cycle's write-back only stops blocking when forwarding is on.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy_eff
      assign busy_eff[gi] = busy_q[gi] & ~(BYPASS & wb_en & (wb_addr == AW'(gi)));
    end
  endgenerate

  // Hazard detection, input handshake and operand read (with optional forwarding).
  always_comb begin
    hazard = in_valid & ((rs1_used   & busy_eff[rs1_idx]) |
                         (rs2_used   & busy_eff[rs2_idx]) |
                         (dec_rd_wen & busy_eff[rd_idx]));
    // Nothing is taken while reset is held, even though the outputs already look empty.
    in_ready = rst & (~out_valid_q | out_ready) & ~hazard & ~flush;
    accept   = in_valid & in_ready;
    issue    = out_valid_q & out_ready & ~flush;

    rs1_rd_data = '0;
    if (rs1_used && rs1_idx != '0)
      rs1_rd_data = (BYPASS && wb_en && wb_addr == rs1_idx) ? wb_data : reg_q[rs1_idx];
    rs2_rd_data = '0;
    if (rs2_used && rs2_idx != '0)
      rs2_rd_data = (BYPASS && wb_en && wb_addr == rs2_idx) ? wb_data : reg_q[rs2_idx];
  end

  // Next state: register file write, scoreboard update, output bundle load/drop.
  always_comb begin
    reg_d          = reg_q;
    busy_d         = busy_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_op_d       = out_op_q;
    out_funct3_d   = out_funct3_q;
    out_funct7b5_d = out_funct7b5_q;
    out_imm_d      = out_imm_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_rd_d       = out_rd_q;
    out_rd_wen_d   = out_rd_wen_q;

    if (wb_en && wb_addr != '0) begin
      reg_d[wb_addr]  = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    // Applied after the write-back clear so an issue to the same register keeps it busy.
    if (issue && out_rd_wen_q)
      busy_d[out_rd_q] = 1'b1;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d    = 1'b1;
      out_pc_d       = in_pc;
      out_op_d       = dec_op;
      out_funct3_d   = funct3;
      out_funct7b5_d = in_inst[30];
      out_imm_d      = dec_imm;
      out_rs1_data_d = rs1_rd_data;
      out_rs2_data_d = rs2_rd_data;
      out_rd_d       = rd_idx;
      out_rd_wen_d   = dec_rd_wen;
    end else if (issue) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
      busy_q         <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_op_q       <= '0;
      out_funct3_q   <= '0;
      out_funct7b5_q <= 1'b0;
      out_imm_q      <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_rd_q       <= '0;
      out_rd_wen_q   <= 1'b0;
    end else begin
      reg_q          <= reg_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_op_q       <= out_op_d;
      out_funct3_q   <= out_funct3_d;
      out_funct7b5_q <= out_funct7b5_d;
      out_imm_q      <= out_imm_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_rd_q       <= out_rd_d;
      out_rd_wen_q   <= out_rd_wen_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_op       = out_op_q;
  assign out_funct3   = out_funct3_q;
  assign out_funct7b5 = out_funct7b5_q;
  assign out_imm      = out_imm_q;
  assign out_rs1_data = out_rs1_data_q;
  assign out_rs2_data = out_rs2_data_q;
  assign out_rd       = out_rd_q;
  assign out_rd_wen   = out_rd_wen_q;

endmodule

// File: tb/tb_idu_pipe_stage.sv
// tb_idu_pipe_stage: directed scenarios plus randomized traffic against a reference model.
// u_dut is the default RV32I/bypassing build; u_dut_e is RV32E without bypass.
module tb_idu_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (NREG=32, BYPASS=1)
  logic        in_valid, in_ready, out_valid, out_ready, out_funct7b5, out_rd_wen, wb_en, flush;
  logic [31:0] in_inst, in_pc, out_pc, out_imm, out_rs1_data, out_rs2_data, wb_data;
  logic [3:0]  out_op;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, wb_addr;

  // RV32E DUT (NREG=16, BYPASS=0)
  logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_out_funct7b5, e_out_rd_wen, e_wb_en, e_flush;
  logic [31:0] e_in_inst, e_in_pc, e_out_pc, e_out_imm, e_out_rs1_data, e_out_rs2_data, e_wb_data;
  logic [3:0]  e_out_op;
  logic [2:0]  e_out_funct3;
  logic [3:0]  e_out_rd, e_wb_addr;

  int n_checks = 0;
  int n_fail   = 0;

  idu_pipe_stage #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
  );

  idu_pipe_stage #(.XLEN(32), .NREG(16), .BYPASS(1'b0)) u_dut_e (
    .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inst(e_in_inst), .in_pc(e_in_pc),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc), .out_op(e_out_op),
    .out_funct3(e_out_funct3), .out_funct7b5(e_out_funct7b5), .out_imm(e_out_imm),
    .out_rs1_data(e_out_rs1_data), .out_rs2_data(e_out_rs2_data), .out_rd(e_out_rd), .out_rd_wen(e_out_rd_wen),
    .wb_en(e_wb_en), .wb_addr(e_wb_addr), .wb_data(e_wb_data), .flush(e_flush)
  );

  task automatic idle_inputs();
    in_valid = 1'b0; in_inst = 32'h0000_0013; in_pc = 32'd0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0;
    e_in_valid = 1'b0; e_in_inst = 32'h0000_0013; e_in_pc = 32'd0; e_out_ready = 1'b1;
    e_wb_en = 1'b0; e_wb_addr = 4'd0; e_wb_data = 32'd0; e_flush = 1'b0;
  endtask

  // Reference decode from the instruction-set rules, using arithmetic on the word.
  function automatic void ref_decode(input logic [31:0] w, output logic [3:0] op, output logic [31:0] imm,
                                     output bit u1, output bit u2, output bit wr);
    logic signed [31:0] sw;
    int opc, f3, f7;
    sw = w; opc = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    op = 4'd15; imm = 32'd0; u1 = 0; u2 = 0; wr = 0;
    if (opc == 'h37) begin op = 4'd0; imm = w & 32'hFFFF_F000; wr = 1; end
    else if (opc == 'h17) begin op = 4'd1; imm = w & 32'hFFFF_F000; wr = 1; end
    else if (opc == 'h6F) begin
      op = 4'd2; wr = 1;
      imm = (w[31] ? 32'hFFF0_0000 : 32'd0) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    end
    else if (opc == 'h67 && f3 == 0) begin op = 4'd3; u1 = 1; wr = 1; imm = 32'(sw >>> 20); end
    else if (opc == 'h63 && f3 != 2 && f3 != 3) begin
      op = 4'd4; u1 = 1; u2 = 1;
      imm = 32'((sw >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    end
    else if (opc == 'h03 && (f3 <= 2 || f3 == 4 || f3 == 5)) begin op = 4'd5; u1 = 1; wr = 1; imm = 32'(sw >>> 20); end
    else if (opc == 'h23 && f3 <= 2) begin
      op = 4'd6; u1 = 1; u2 = 1; imm = 32'((sw >>> 25) << 5) | 32'(w[11:7]);
    end
    else if (opc == 'h13) begin op = 4'd7; u1 = 1; wr = 1; imm = 32'(sw >>> 20); end
    else if (opc == 'h33 && (f7 == 0 || f7 == 'h20)) begin op = 4'd8; u1 = 1; u2 = 1; wr = 1; end
    else if (w == 32'h0010_0073) op = 4'd9;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] r;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7)); r = $urandom;
    case ($urandom_range(0, 11))
      0:       return {r[31:12], rd, 7'h37};
      1:       return {r[31:12], rd, 7'h17};
      2:       return {r[31:12], rd, 7'h6F};
      3:       return {r[31:20], rs1, (r[0] ? f3 : 3'd0), rd, 7'h67};
      4:       return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      5:       return {r[31:20], rs1, f3, rd, 7'h03};
      6:       return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
      7, 8:    return {r[31:20], rs1, f3, rd, 7'h13};
      9:       return {((r[1] & r[2]) ? r[31:25] : (r[0] ? 7'h20 : 7'h00)), rs2, rs1, f3, rd, 7'h33};
      10:      return 32'h0010_0073;
      default: return r;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0; in_valid = 1'b1; in_inst = 32'h0010_8133; in_pc = 32'h40; e_in_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if ({out_pc, out_op, out_funct3, out_funct7b5, out_imm, out_rs1_data, out_rs2_data, out_rd, out_rd_wen} !== '0)
        begin n_fail++; $display("FAIL reset_outputs_zero: pc=%h op=%0d imm=%h rd=%0d", out_pc, out_op, out_imm, out_rd); end
      n_checks++; if ({e_out_valid, e_in_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_e_valid_ready: got %b want 00", {e_out_valid, e_in_ready}); end
    end
    // Release with add x2,x1,x1 still presented: registers must read as zero.
    rst = 1'b1; e_in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_op, out_rs1_data, out_rs2_data} !== {1'b1, 4'd8, 32'd0, 32'd0})
      begin n_fail++; $display("FAIL post_reset_read_zero: got v=%b op=%0d rs1=%h rs2=%h want v=1 op=8 rs1=0 rs2=0", out_valid, out_op, out_rs1_data, out_rs2_data); end
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd0;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic test_raw_stall();
    in_valid = 1'b1; in_inst = 32'hFFB0_0093; in_pc = 32'h100; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_accept_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_op, out_imm, out_rd, out_rd_wen, out_pc} !== {1'b1, 4'd7, 32'hFFFF_FFFB, 5'd1, 1'b1, 32'h100})
      begin n_fail++; $display("FAIL addi_bundle: got v=%b op=%0d imm=%h rd=%0d wen=%b pc=%h want v=1 op=7 imm=fffffffb rd=1 wen=1 pc=100", out_valid, out_op, out_imm, out_rd, out_rd_wen, out_pc); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_issued_drop: got %b want 0", out_valid); end
    in_valid = 1'b1; in_inst = 32'h0010_8133; in_pc = 32'h104;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_cycle%0d: in_ready got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hFFFF_FFFB;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release_with_wb: in_ready got %b want 1", in_ready); end
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
    n_checks++; if ({out_valid, out_op, out_rs1_data, out_rs2_data, out_rd} !== {1'b1, 4'd8, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 5'd2})
      begin n_fail++; $display("FAIL add_operands: got v=%b op=%0d rs1=%h rs2=%h rd=%0d want v=1 op=8 rs1=fffffffb rs2=fffffffb rd=2", out_valid, out_op, out_rs1_data, out_rs2_data, out_rd); end
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd5;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; in_inst = 32'h0010_0193; in_pc = 32'h200; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h0030_2423; in_pc = 32'h204;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_same_cycle_ready: got %b want 1", in_ready); end
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
    n_checks++; if ({out_valid, out_op, out_imm, out_rs1_data, out_rs2_data, out_rd_wen} !== {1'b1, 4'd6, 32'd8, 32'd0, 32'h1234, 1'b0})
      begin n_fail++; $display("FAIL bypass_sw_bundle: got v=%b op=%0d imm=%h rs1=%h rs2=%h wen=%b want v=1 op=6 imm=8 rs1=0 rs2=1234 wen=0", out_valid, out_op, out_imm, out_rs1_data, out_rs2_data, out_rd_wen); end
    @(negedge clk);
  endtask

  task automatic test_no_bypass();
    e_in_valid = 1'b1; e_in_inst = 32'h0010_0193; e_in_pc = 32'h300; e_out_ready = 1'b1;
    @(negedge clk);
    e_in_valid = 1'b0;
    @(negedge clk);
    e_in_valid = 1'b1; e_in_inst = 32'h0030_2423; e_in_pc = 32'h304;
    e_wb_en = 1'b1; e_wb_addr = 4'd3; e_wb_data = 32'h1234;
    #1;
    n_checks++; if (e_in_ready !== 1'b0) begin n_fail++; $display("FAIL nobypass_stall: in_ready got %b want 0", e_in_ready); end
    @(negedge clk);
    e_wb_en = 1'b0;
    n_checks++; if (e_out_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_not_taken: out_valid got %b want 0", e_out_valid); end
    #1;
    n_checks++; if (e_in_ready !== 1'b1) begin n_fail++; $display("FAIL nobypass_release: in_ready got %b want 1", e_in_ready); end
    @(negedge clk);
    e_in_valid = 1'b0;
    n_checks++; if ({e_out_valid, e_out_op, e_out_imm, e_out_rs2_data} !== {1'b1, 4'd6, 32'd8, 32'h1234})
      begin n_fail++; $display("FAIL nobypass_sw_bundle: got v=%b op=%0d imm=%h rs2=%h want v=1 op=6 imm=8 rs2=1234", e_out_valid, e_out_op, e_out_imm, e_out_rs2_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_inst = 32'hABCD_E2B7; in_pc = 32'h400; out_ready = 1'b0;
    @(negedge clk);
    in_inst = 32'h0070_0313; in_pc = 32'h404;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if ({out_valid, out_op, out_imm, out_rd, out_pc} !== {1'b1, 4'd0, 32'hABCD_E000, 5'd5, 32'h400})
        begin n_fail++; $display("FAIL hold_bundle_cycle%0d: got v=%b op=%0d imm=%h rd=%0d pc=%h want v=1 op=0 imm=abcde000 rd=5 pc=400", c, out_valid, out_op, out_imm, out_rd, out_pc); end
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready_cycle%0d: got %b want 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if ({out_valid, out_op, out_imm, out_rd, out_pc} !== {1'b1, 4'd7, 32'd7, 5'd6, 32'h404})
      begin n_fail++; $display("FAIL back_to_back_next: got v=%b op=%0d imm=%h rd=%0d pc=%h want v=1 op=7 imm=7 rd=6 pc=404", out_valid, out_op, out_imm, out_rd, out_pc); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_inst = 32'h0030_0393; in_pc = 32'h500; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1; in_inst = 32'h0073_8433; in_pc = 32'h504;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    #1;
    // add x8,x7,x7 is only accepted if the flushed addi x7 left x7 not busy.
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_no_busy: in_ready got %b want 1", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rv32e();
    e_in_valid = 1'b1; e_in_inst = 32'h0010_0A13; e_in_pc = 32'h600; e_out_ready = 1'b1;
    @(negedge clk);
    e_in_inst = 32'h0010_0073; e_in_pc = 32'h604;
    n_checks++; if ({e_out_valid, e_out_op, e_out_rd_wen, e_out_imm} !== {1'b1, 4'd15, 1'b0, 32'd0})
      begin n_fail++; $display("FAIL rv32e_x20_illegal: got v=%b op=%0d wen=%b imm=%h want v=1 op=15 wen=0 imm=0", e_out_valid, e_out_op, e_out_rd_wen, e_out_imm); end
    @(negedge clk);
    e_in_valid = 1'b0;
    n_checks++; if ({e_out_valid, e_out_op, e_out_rd_wen, e_out_imm} !== {1'b1, 4'd9, 1'b0, 32'd0})
      begin n_fail++; $display("FAIL rv32e_ebreak: got v=%b op=%0d wen=%b imm=%h want v=1 op=9 wen=0 imm=0", e_out_valid, e_out_op, e_out_rd_wen, e_out_imm); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid, m_wen;
    logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d;
    logic [3:0]  m_op;
    logic [2:0]  m_f3;
    logic        m_f7b5;
    logic [4:0]  m_rd;
    logic [3:0]  d_op;
    logic [31:0] d_imm, r1, r2;
    bit          u1, u2, wr, wen, hz, exp_ready, acc, iss;
    int          rs1, rs2, rd, busy_list[$];

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_busy[i] = 0; end
    m_valid = 0; m_wen = 0; m_pc = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0; m_op = 0; m_f3 = 0; m_f7b5 = 0; m_rd = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rand_out_valid cyc%0d: got %b want %b", cyc, out_valid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if ({out_pc, out_op, out_funct3, out_funct7b5, out_imm, out_rs1_data, out_rs2_data, out_rd, out_rd_wen} !==
            {m_pc, m_op, m_f3, m_f7b5, m_imm, m_rs1d, m_rs2d, m_rd, m_wen}) begin
          n_fail++;
          $display("FAIL rand_bundle cyc%0d: got pc=%h op=%0d f3=%0d f7b5=%b imm=%h rs1=%h rs2=%h rd=%0d wen=%b want pc=%h op=%0d f3=%0d f7b5=%b imm=%h rs1=%h rs2=%h rd=%0d wen=%b",
                   cyc, out_pc, out_op, out_funct3, out_funct7b5, out_imm, out_rs1_data, out_rs2_data, out_rd, out_rd_wen,
                   m_pc, m_op, m_f3, m_f7b5, m_imm, m_rs1d, m_rs2d, m_rd, m_wen);
        end
      end

      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_data   = $urandom;
      busy_list.delete();
      for (int i = 1; i < 32; i++) if (m_busy[i]) busy_list.push_back(i);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        wb_addr = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wb_addr = 5'($urandom_range(0, 7));
      #1;

      ref_decode(in_inst, d_op, d_imm, u1, u2, wr);
      rs1 = int'(in_inst[19:15]); rs2 = int'(in_inst[24:20]); rd = int'(in_inst[11:7]);
      wen = wr && (rd != 0);
      // A register being written back this cycle is treated as no longer busy.
      hz = in_valid && ((u1 && m_busy[rs1] && !(wb_en && int'(wb_addr) == rs1)) ||
                        (u2 && m_busy[rs2] && !(wb_en && int'(wb_addr) == rs2)) ||
                        (wen && m_busy[rd] && !(wb_en && int'(wb_addr) == rd)));
      exp_ready = (!m_valid || out_ready) && !hz && !flush;
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready cyc%0d: got %b want %b (inst %h)", cyc, in_ready, exp_ready, in_inst); end

      r1 = (!u1 || rs1 == 0) ? 32'd0 : ((wb_en && int'(wb_addr) == rs1) ? wb_data : m_regs[rs1]);
      r2 = (!u2 || rs2 == 0) ? 32'd0 : ((wb_en && int'(wb_addr) == rs2) ? wb_data : m_regs[rs2]);
      acc = in_valid && exp_ready;
      iss = m_valid && out_ready && !flush;
      if (wb_en && wb_addr != 5'd0) begin m_regs[wb_addr] = wb_data; m_busy[wb_addr] = 0; end
      if (iss && m_wen) m_busy[m_rd] = 1;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_pc = in_pc; m_op = d_op; m_f3 = in_inst[14:12]; m_f7b5 = in_inst[30];
        m_imm = d_imm; m_rs1d = r1; m_rs2d = r2; m_rd = in_inst[11:7]; m_wen = wen;
      end else if (iss) m_valid = 0;

      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_bypass();
    test_no_bypass();
    test_backpressure();
    test_flush();
    test_rv32e();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
